uart_tx: RTL and testbench

- 8-bit UART transmitter, the transmit end of the existing UART receive path.
- Serialises one byte per valid/ready handshake onto the `tx` line: start bit, 8 data bits LSB first, then stop bit(s).
- Defaults match the receive side: 100 MHz clock, 9600 baud, 10417 clocks per bit (104170 ns).
- Sits between a byte source (command logic or loopback from the receiver) and the board TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_W               = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 10417;

  localparam logic UART_LINE_IDLE  = 1'b1;
  localparam logic UART_LINE_START = 1'b0;
  localparam logic UART_LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period tick counter: counts 0..CLKS_PER_BIT-1, tick_o on the last count.
// restart_i holds the count at zero (used while the owner is idle).
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart_i,
  output logic tick_o
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with valid/ready byte input and a registered tx line.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: illegal parameter combination");
  end

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock     (clock),
    .resetn    (resetn),
    .restart_i (state_q == ST_IDLE),
    .tick_o    (tick)
  );

  assign tx       = tx_q;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_STOP) && tick && (idx_q == STOP_LAST);

  // tx_d is the level for the *next* cycle, so the line changes on the same
  // edge as the state and stays a pure flop output.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_LINE_IDLE;
        if (tx_valid) begin
          shift_d = tx_data;
          idx_d   = '0;
          tx_d    = UART_LINE_START;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ PARITY_ODD[0];
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = UART_LINE_STOP;
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tx_d    = UART_LINE_STOP;
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            tx_d    = UART_LINE_IDLE;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        tx_d    = UART_LINE_IDLE;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= UART_LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed + random bench for uart_tx: two instances (16 clk/bit 1 stop even,
// 5 clk/bit 2 stop odd) checked cycle by cycle against a bit-period line model.
module tb_uart_tx;

  localparam int CPB_A = 16, STOP_A = 1, ODD_A = 0;
  localparam int CPB_B = 5,  STOP_B = 2, ODD_B = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(STOP_A), .PARITY_ODD(ODD_A)) dut_a (
    .clock(clock), .resetn(resetn), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(STOP_B), .PARITY_ODD(ODD_B)) dut_b (
    .clock(clock), .resetn(resetn), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level t cycles after the accept edge: bit b = t / cpb of the frame.
  function automatic logic exp_line(input logic [7:0] d, input int t, input int cpb, input int odd);
    int b;
    logic o;
    b = t / cpb;
    o = (odd != 0);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR == 1 && b == 9) return (^d) ^ o;
    return 1'b1;
  endfunction

  // Starts at a negedge with the DUT idle; ends at the negedge of the first
  // cycle after the frame. hold keeps valid high with nxt as the next byte.
  task automatic frame(input bit sel, input logic [7:0] d, input bit hold,
                       input logic [7:0] nxt, input bit poke, output logic [15:0] midv);
    int cpb, stp, odd, len;
    int le, de, be, re;
    logic l_tx, l_done, l_busy, l_ready;
    cpb = sel ? CPB_B : CPB_A;
    stp = sel ? STOP_B : STOP_A;
    odd = sel ? ODD_B : ODD_A;
    len = (1 + 8 + PAR + stp) * cpb;
    le = 0; de = 0; be = 0; re = 0; midv = '0;
    chk($sformatf("ready_pre_%0d_%h", sel, d), sel ? ready_b : ready_a, 1);
    if (sel) begin data_b = d; valid_b = 1'b1; end
    else     begin data_a = d; valid_a = 1'b1; end
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      if (sel) data_b = nxt; else data_a = nxt;
    end else begin
      if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    end
    for (int t = 0; t < len; t++) begin
      l_tx    = sel ? tx_b    : tx_a;
      l_done  = sel ? done_b  : done_a;
      l_busy  = sel ? busy_b  : busy_a;
      l_ready = sel ? ready_b : ready_a;
      if (l_tx !== exp_line(d, t, cpb, odd)) le++;
      if (l_done !== (t == len - 1)) de++;
      if (l_busy !== 1'b1) be++;
      if (l_ready !== 1'b0) re++;
      if (t % cpb == cpb / 2) midv[t / cpb] = l_tx;
      if (poke && !hold && t == len / 2) begin
        if (sel) begin valid_b = 1'b1; data_b = 8'($urandom); end
        else     begin valid_a = 1'b1; data_a = 8'($urandom); end
      end
      if (poke && !hold && t == len / 2 + 1) begin
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
      end
      @(negedge clock);
    end
    chk($sformatf("line_bad_cycles_%0d_%h", sel, d), le, 0);
    chk($sformatf("done_bad_cycles_%0d_%h", sel, d), de, 0);
    chk($sformatf("busy_bad_cycles_%0d_%h", sel, d), be, 0);
    chk($sformatf("ready_bad_cycles_%0d_%h", sel, d), re, 0);
    chk($sformatf("tx_after_%0d_%h", sel, d), sel ? tx_b : tx_a, 1);
    chk($sformatf("busy_after_%0d_%h", sel, d), sel ? busy_b : busy_a, 0);
    chk($sformatf("ready_after_%0d_%h", sel, d), sel ? ready_b : ready_a, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mv;
    int rb;
    logic [7:0] rd;
    bit rs;

    // Reset held for 5 cycles: idle outputs throughout
    rb = 0;
    repeat (5) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) rb++;
      if (tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) rb++;
    end
    chk("reset_hold_bad_cycles", rb, 0);
    resetn = 1'b1;
    rb = 0;
    repeat (3) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) rb++;
    end
    chk("post_reset_idle_bad_cycles", rb, 0);

    // Single byte A5
    frame(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, mv);
`ifndef UART_TX_PARITY_EN
    chk("a5_midbit_samples", mv[9:0], 10'b1_1010_0101_0);
`endif

    // Back-to-back, data changed while busy, mid-frame valid pulse ignored
    frame(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, mv);
    frame(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, mv);

    // Reset in D3 of 3C
    data_a = 8'h3C; valid_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_a = 1'b0;
    repeat (4 * CPB_A + 7) @(negedge clock);
    chk("mid_frame_busy_before_reset", busy_a, 1);
    #1 resetn = 1'b0;
    #1;
    chk("reset_mid_tx", tx_a, 1);
    chk("reset_mid_busy", busy_a, 0);
    chk("reset_mid_ready", ready_a, 1);
    rb = 0;
    repeat (3) begin
      @(negedge clock);
      if (done_a !== 1'b0 || tx_a !== 1'b1) rb++;
    end
    chk("reset_mid_no_done", rb, 0);
    resetn = 1'b1;
    @(negedge clock);
    frame(1'b0, 8'h55, 1'b0, 8'h00, 1'b0, mv);

    // Two stop bits on the second instance
    frame(1'b1, 8'h41, 1'b0, 8'h00, 1'b0, mv);
`ifndef UART_TX_PARITY_EN
    chk("b41_midbit_samples", mv[10:0], 11'b11_0100_0001_0);
`endif

`ifdef UART_TX_PARITY_EN
    frame(1'b0, 8'h07, 1'b0, 8'h00, 1'b0, mv);
    chk("parity_even_07", mv[9], 1);
    frame(1'b1, 8'h07, 1'b0, 8'h00, 1'b0, mv);
    chk("parity_odd_07", mv[9], 0);
`endif

    // Random bytes on random instances with random idle gaps
    repeat (8) begin
      rs = 1'($urandom);
      rd = 8'($urandom);
      rb = 0;
      repeat ($urandom_range(0, 4)) begin
        @(negedge clock);
        if ((rs ? tx_b : tx_a) !== 1'b1) rb++;
      end
      chk("gap_idle_bad_cycles", rb, 0);
      frame(rs, rd, 1'b0, 8'h00, 1'($urandom), mv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
